// File: rtl/risc_pkg.sv
// Shared definitions for the RISC run controller, core and benches:
// run-controller state encoding and default widths/limits.
package risc_pkg;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_PROG_DEPTH = 256;
   localparam int DEF_MAX_CYCLES = 50;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } runState_t;

endpackage

// File: rtl/risc_prog_ram.sv
// Program store: one write port, one registered read port.
// Only the read register is reset; the contents survive reset.
module risc_prog_ram
   import risc_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int PROG_DEPTH = DEF_PROG_DEPTH,
   localparam int ADDR_W    = $clog2(PROG_DEPTH)
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [PROG_DEPTH];
   logic [DATA_W-1:0] r_rdData;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // A read that collides with a write returns the old word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdData <= '0;
      end else begin
         r_rdData <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rdData;

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller: loads a program into the store, holds the core in reset
// outside a run, and ends the run on core halt or watchdog expiry.
module risc_run_ctrl
   import risc_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int PROG_DEPTH = DEF_PROG_DEPTH,
   parameter int MAX_CYCLES = DEF_MAX_CYCLES,
   localparam int ADDR_W    = $clog2(PROG_DEPTH)
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_load_last,
   output logic              o_load_ready,
   input  logic              i_start,
   input  logic              i_core_halt,
   input  logic [ADDR_W-1:0] i_imem_addr,
   output logic [DATA_W-1:0] o_imem_data,
   output logic              o_core_rst,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout,
   output logic [31:0]       o_cycle_count,
   output logic [ADDR_W:0]   o_prog_len
);

   localparam int               LEN_W     = ADDR_W + 1;
   localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(PROG_DEPTH);
   localparam logic [31:0]      MAX_CNT   = 32'(MAX_CYCLES);

   runState_t         r_state;
   runState_t         w_nextState;
   logic [LEN_W-1:0]  r_progLen;
   logic [31:0]       r_cycleCount;
   logic [31:0]       w_cntNext;
   logic              w_loadAccept;
   logic              w_startOk;
   logic              w_enterRun;
   logic [ADDR_W-1:0] w_wrAddr;

   assign o_load_ready = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) &&
                         (r_progLen < DEPTH_LEN);
   assign w_loadAccept = i_load_valid && o_load_ready;
   assign w_startOk    = i_start && (r_progLen != '0);
   assign w_cntNext    = (r_cycleCount == '1) ? r_cycleCount : r_cycleCount + 32'd1;
   // A load begun from IDLE always restarts at address 0.
   assign w_wrAddr     = (r_state == ST_IDLE) ? '0 : r_progLen[ADDR_W-1:0];
   assign w_enterRun   = (r_state != ST_RUN) && (w_nextState == ST_RUN);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_loadAccept) begin
               w_nextState = i_load_last ? ST_IDLE : ST_LOAD;
            end else if (w_startOk) begin
               w_nextState = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (w_loadAccept && (i_load_last || (r_progLen + 1'b1 == DEPTH_LEN))) begin
               w_nextState = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Halt takes priority over a watchdog expiry in the same cycle.
            if (i_core_halt) begin
               w_nextState = ST_DONE;
            end else if (w_cntNext >= MAX_CNT) begin
               w_nextState = ST_TIMEOUT;
            end
         end
         ST_DONE, ST_TIMEOUT: begin
            if (w_startOk) begin
               w_nextState = ST_RUN;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_progLen    <= '0;
         r_cycleCount <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_loadAccept) begin
            r_progLen <= (r_state == ST_IDLE) ? LEN_W'(1) : r_progLen + 1'b1;
         end
         // The halt cycle itself is not counted.
         if (w_enterRun) begin
            r_cycleCount <= '0;
         end else if ((r_state == ST_RUN) && !i_core_halt) begin
            r_cycleCount <= w_cntNext;
         end
      end
   end

   risc_prog_ram #(
      .DATA_W     (DATA_W),
      .PROG_DEPTH (PROG_DEPTH)
   ) u_progRam (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_loadAccept),
      .i_wr_addr (w_wrAddr),
      .i_wr_data (i_load_data),
      .i_rd_addr (i_imem_addr),
      .o_rd_data (o_imem_data)
   );

   assign o_core_rst    = (r_state != ST_RUN);
   assign o_busy        = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign o_done        = (r_state == ST_DONE);
   assign o_timeout     = (r_state == ST_TIMEOUT);
   assign o_cycle_count = r_cycleCount;
   assign o_prog_len    = r_progLen;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Directed bench for risc_run_ctrl: load, fetch, halt, watchdog, reset abort
// and full-store loading, with hand-computed expectations.
module tb_risc_run_ctrl;

   localparam int DATA_W     = 16;
   localparam int PROG_DEPTH = 8;
   localparam int MAX_CYCLES = 50;
   localparam int ADDR_W     = $clog2(PROG_DEPTH);

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b0;
   logic              i_load_valid = 1'b0;
   logic [DATA_W-1:0] i_load_data = '0;
   logic              i_load_last = 1'b0;
   logic              o_load_ready;
   logic              i_start = 1'b0;
   logic              i_core_halt = 1'b0;
   logic [ADDR_W-1:0] i_imem_addr = '0;
   logic [DATA_W-1:0] o_imem_data;
   logic              o_core_rst;
   logic              o_busy;
   logic              o_done;
   logic              o_timeout;
   logic [31:0]       o_cycle_count;
   logic [ADDR_W:0]   o_prog_len;

   int checkCount = 0;
   int errorCount = 0;

   always #5 i_clk = ~i_clk;

   risc_run_ctrl #(
      .DATA_W     (DATA_W),
      .PROG_DEPTH (PROG_DEPTH),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_load_valid  (i_load_valid),
      .i_load_data   (i_load_data),
      .i_load_last   (i_load_last),
      .o_load_ready  (o_load_ready),
      .i_start       (i_start),
      .i_core_halt   (i_core_halt),
      .i_imem_addr   (i_imem_addr),
      .o_imem_data   (o_imem_data),
      .o_core_rst    (o_core_rst),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_timeout     (o_timeout),
      .o_cycle_count (o_cycle_count),
      .o_prog_len    (o_prog_len)
   );

   // Drive one cycle of inputs, then return 1 time unit after the rising edge.
   task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data,
                                input logic last, input logic start, input logic halt);
      i_load_valid = valid;
      i_load_data  = data;
      i_load_last  = last;
      i_start      = start;
      i_core_halt  = halt;
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   initial begin
      int n;

      // Reset
      i_rst = 1'b1;
      applyStimulus(0, '0, 0, 0, 0);
      applyStimulus(0, '0, 0, 0, 0);
      i_rst = 1'b0;
      checkOutput("rst_core_rst", 32'(o_core_rst), 1);
      checkOutput("rst_busy", 32'(o_busy), 0);
      checkOutput("rst_done", 32'(o_done), 0);
      checkOutput("rst_timeout", 32'(o_timeout), 0);
      checkOutput("rst_count", o_cycle_count, 0);
      checkOutput("rst_prog_len", 32'(o_prog_len), 0);
      checkOutput("rst_imem", 32'(o_imem_data), 0);
      checkOutput("rst_ready", 32'(o_load_ready), 1);

      // Load four words, last on the fourth
      applyStimulus(1, 16'h1111, 0, 0, 0);
      checkOutput("load1_busy", 32'(o_busy), 1);
      checkOutput("load1_len", 32'(o_prog_len), 1);
      applyStimulus(1, 16'h2222, 0, 0, 0);
      applyStimulus(1, 16'h3333, 0, 0, 0);
      applyStimulus(1, 16'h4444, 1, 0, 0);
      checkOutput("load4_len", 32'(o_prog_len), 4);
      checkOutput("load4_ready", 32'(o_load_ready), 1);
      checkOutput("load4_busy", 32'(o_busy), 0);
      i_imem_addr = 3'd2;
      applyStimulus(0, '0, 0, 0, 0);
      checkOutput("fetch_a2", 32'(o_imem_data), 32'h3333);
      i_imem_addr = 3'd0;
      applyStimulus(0, '0, 0, 0, 0);
      checkOutput("fetch_a0", 32'(o_imem_data), 32'h1111);

      // Run, core halts on its 10th enabled cycle
      applyStimulus(0, '0, 0, 1, 0);
      checkOutput("run_core_rst", 32'(o_core_rst), 0);
      checkOutput("run_busy", 32'(o_busy), 1);
      checkOutput("run_count0", o_cycle_count, 0);
      repeat (9) applyStimulus(0, '0, 0, 0, 0);
      checkOutput("run_count9", o_cycle_count, 9);
      applyStimulus(0, '0, 0, 0, 1);
      checkOutput("halt_done", 32'(o_done), 1);
      checkOutput("halt_count", o_cycle_count, 9);
      checkOutput("halt_core_rst", 32'(o_core_rst), 1);
      checkOutput("halt_timeout", 32'(o_timeout), 0);
      checkOutput("halt_busy", 32'(o_busy), 0);

      // Restart from DONE, no halt: watchdog; start and load offered mid-run are ignored
      applyStimulus(0, '0, 0, 1, 0);
      checkOutput("rerun_done_clr", 32'(o_done), 0);
      checkOutput("rerun_count0", o_cycle_count, 0);
      n = 0;
      while (!o_timeout && n < 100) begin
         applyStimulus(1, 16'hDEAD, 1, (n == 20), 0);
         n++;
         if (n == 10) checkOutput("run_ready_low", 32'(o_load_ready), 0);
      end
      i_load_valid = 1'b0;
      checkOutput("wd_timeout", 32'(o_timeout), 1);
      checkOutput("wd_cycles", 32'(n), 50);
      checkOutput("wd_count", o_cycle_count, 50);
      checkOutput("wd_done", 32'(o_done), 0);
      checkOutput("wd_prog_len", 32'(o_prog_len), 4);
      repeat (3) applyStimulus(0, '0, 0, 0, 0);
      checkOutput("wd_hold", 32'(o_timeout), 1);

      // Restart from TIMEOUT, halt in the same cycle the watchdog would expire
      applyStimulus(0, '0, 0, 1, 0);
      checkOutput("rerun_to_clr", 32'(o_timeout), 0);
      repeat (49) applyStimulus(0, '0, 0, 0, 0);
      checkOutput("race_count49", o_cycle_count, 49);
      checkOutput("race_busy", 32'(o_busy), 1);
      applyStimulus(0, '0, 0, 0, 1);
      checkOutput("race_done", 32'(o_done), 1);
      checkOutput("race_timeout", 32'(o_timeout), 0);
      checkOutput("race_count", o_cycle_count, 49);

      // Reset on run cycle 5 with other inputs active
      i_imem_addr = 3'd2;
      applyStimulus(0, '0, 0, 1, 0);
      repeat (4) applyStimulus(0, '0, 0, 0, 0);
      checkOutput("abort_count4", o_cycle_count, 4);
      i_rst = 1'b1;
      applyStimulus(1, 16'h5555, 0, 1, 1);
      i_rst = 1'b0;
      checkOutput("abort_busy", 32'(o_busy), 0);
      checkOutput("abort_done", 32'(o_done), 0);
      checkOutput("abort_timeout", 32'(o_timeout), 0);
      checkOutput("abort_count", o_cycle_count, 0);
      checkOutput("abort_len", 32'(o_prog_len), 0);
      checkOutput("abort_core_rst", 32'(o_core_rst), 1);
      checkOutput("abort_imem", 32'(o_imem_data), 0);
      applyStimulus(0, '0, 0, 1, 0);
      checkOutput("nolen_busy", 32'(o_busy), 0);
      checkOutput("nolen_core_rst", 32'(o_core_rst), 1);
      checkOutput("store_kept", 32'(o_imem_data), 32'h3333);

      // Fill the store without a last marker; a further word is refused
      for (int k = 0; k < PROG_DEPTH; k++) begin
         applyStimulus(1, 16'hA000 + 16'(k), 0, 0, 0);
      end
      checkOutput("full_len", 32'(o_prog_len), 8);
      checkOutput("full_ready", 32'(o_load_ready), 0);
      checkOutput("full_busy", 32'(o_busy), 0);
      applyStimulus(1, 16'hBEEF, 0, 0, 0);
      checkOutput("extra_len", 32'(o_prog_len), 8);
      i_imem_addr = 3'd0;
      applyStimulus(0, '0, 0, 0, 0);
      checkOutput("full_a0", 32'(o_imem_data), 32'hA000);
      i_imem_addr = 3'd7;
      applyStimulus(0, '0, 0, 0, 0);
      checkOutput("full_a7", 32'(o_imem_data), 32'hA007);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
